bus_arbiter_decoder: RTL and testbench
======================================

Name: bus_arbiter_decoder

Overview:
- Upstream control stage of the shared bus; drives the select input of the 3:1 32-bit read-data mux.
- Arbitrates between two bus masters (M0, M1) with a two-state grant FSM, steers the granted master's address/write signals onto the shared slave bus, and decodes the address into slave selects.
- Slaves are synchronous RAMs with one-cycle read latency, so the read-data select is a registered copy of the decode result: mux input d0 = slave0 rdata, d1 = slave1 rdata, d2 = default/error data.

Parameters:
- ADDR_W, 8, address width of both masters and the shared bus (minimum 4).
- DATA_W, 32, write-data width (matches the 32-bit read mux).

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- m0_req  input  1  master 0 bus request
- m0_wr  input  1  master 0 write enable (1=write, 0=read)
- m0_addr  input  ADDR_W  master 0 address
- m0_dout  input  DATA_W  master 0 write data
- m1_req  input  1  master 1 bus request
- m1_wr  input  1  master 1 write enable
- m1_addr  input  ADDR_W  master 1 address
- m1_dout  input  DATA_W  master 1 write data
- m0_grant  output  1  master 0 owns bus
- m1_grant  output  1  master 1 owns bus
- s_addr  output  ADDR_W  shared bus address
- s_wr  output  1  shared bus write enable
- s_din  output  DATA_W  shared bus write data
- s0_sel  output  1  slave 0 chip select
- s1_sel  output  1  slave 1 chip select
- rsel  output  2  read-data mux select (00 slave0, 01 slave1, 10 default)

Behaviour:
- Single clock domain; reset is synchronous and active-high: sampled only on rising clk edge with reset=1.
- FSM states: M0_GNT, M1_GNT; reset state M0_GNT.
- In M0_GNT:
  - m0_req=1 -> stay.
  - m0_req=0 and m1_req=1 -> M1_GNT.
  - otherwise stay (bus parks on M0).
- In M1_GNT:
  - m1_req=1 -> stay.
  - m1_req=0 -> M0_GNT, regardless of m0_req (M0 is the default owner).
- Simultaneous requests: the current owner keeps the bus while its req is high; there is no preemption. Ownership changes only on the owner's release.
- m0_grant = (state==M0_GNT), m1_grant = (state==M1_GNT): exactly one grant is high at all times, including during and after reset.
- Bus steering is combinational from the state:
  - In M0_GNT, s_addr/s_wr/s_din = m0_addr/m0_wr/m0_dout; in M1_GNT, the M1 equivalents.
  - s_wr is forced to 0 when the granted master's req=0.
- Decode uses active = granted master's req and the top two address bits (tag = s_addr[ADDR_W-1:ADDR_W-2]):
  - tag==2'b00 -> s0_sel = active.
  - tag==2'b01 -> s1_sel = active.
  - tag 2'b10/2'b11 -> no slave selected (unmapped).
  - s0_sel and s1_sel are never both high.
- rsel is registered, one-cycle latency, aligned with slave rdata:
  - next rsel = 00 if s0_sel, 01 if s1_sel, 10 otherwise (idle, write, or unmapped address). Writes also give 10.
  - rsel reflects the access issued in the previous cycle.
- Reset values: state=M0_GNT, m0_grant=1, m1_grant=0, rsel=2'b10.
- Combinational outputs during reset follow M0 inputs with the rules above.
- Reset mid-transfer: on the next edge the state returns to M0_GNT and rsel goes to 10, even if M1 holds its req; the pending M1 read's rsel is discarded.
- Grant handover cycle: the address on the handover edge belongs to the new owner. rsel in the following cycle reflects the old owner's last access, as computed by the registered path.

Test Plan:
- Reset with m1_req=1, m1_addr=8'h40 -> m0_grant=1, m1_grant=0, rsel=2'b10 one cycle after reset; M1 is granted on the first edge after reset deasserts (m0_req=0).
- M0 read: m0_req=1, m0_wr=0, m0_addr=8'h05 -> s0_sel=1, s_addr=8'h05, s_wr=0 same cycle; rsel=2'b00 next cycle; with mux d0=32'h1111_1111, y=32'h1111_1111.
- M1 write then read: m0_req=0, m1_req=1, m1_wr=1, m1_addr=8'h48, m1_dout=32'h2222_2222 -> m1_grant=1 after one edge, s1_sel=1, s_wr=1, s_din=32'h2222_2222, rsel=2'b10. Switching to m1_wr=0 gives rsel=2'b01 one cycle later.
- Contention: M0 holds m0_req=1 for 4 cycles while m1_req=1 -> m0_grant stays 1. m0_req drops -> m1_grant=1 on the next edge. m1_req drops -> m0_grant=1 on the following edge.
- Unmapped address: granted master reads 8'hC0 -> s0_sel=s1_sel=0, rsel=2'b10 next cycle; mux outputs d2=32'h3333_3333.
- Reset asserted mid-M1 read (m1_addr=8'h41) -> next edge m0_grant=1 and rsel=2'b10; no slave-1 select is generated from M1 after that edge.

Source files
------------

// File: rtl/bus_arbiter_decoder.sv
// Two-master bus arbiter with address steering and slave decode.
// rsel is registered to line up with the one-cycle read latency of the slave RAMs.
module bus_arbiter_decoder #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_dout,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_dout,
  output logic              m0_grant,
  output logic              m1_grant,
  output logic [ADDR_W-1:0] s_addr,
  output logic              s_wr,
  output logic [DATA_W-1:0] s_din,
  output logic              s0_sel,
  output logic              s1_sel,
  output logic [1:0]        rsel
);

  localparam int unsigned TAG_W = 2;

  localparam logic [TAG_W-1:0] TAG_S0 = 2'b00;
  localparam logic [TAG_W-1:0] TAG_S1 = 2'b01;

  localparam logic [1:0] RSEL_S0  = 2'b00;
  localparam logic [1:0] RSEL_S1  = 2'b01;
  localparam logic [1:0] RSEL_DEF = 2'b10;

  typedef enum logic {
    M0_GNT = 1'b0,
    M1_GNT = 1'b1
  } state_t;

  state_t           state;
  logic             active_c;
  logic [TAG_W-1:0] tag_c;
  logic [1:0]       rsel_nxt_c;

  // Grant FSM: owner keeps the bus while requesting; M0 is the parking owner.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= M0_GNT;
      rsel  <= RSEL_DEF;
    end else begin
      case (state)
        M0_GNT:  state <= (!m0_req && m1_req) ? M1_GNT : M0_GNT;
        M1_GNT:  state <= m1_req ? M1_GNT : M0_GNT;
        default: state <= M0_GNT;
      endcase
      rsel <= rsel_nxt_c;
    end
  end

  assign m0_grant = (state == M0_GNT);
  assign m1_grant = (state == M1_GNT);

  // Steer the owner's request onto the shared bus and decode the slave.
  always_comb begin
    active_c   = 1'b0;
    s_addr     = m0_addr;
    s_wr       = 1'b0;
    s_din      = m0_dout;
    s0_sel     = 1'b0;
    s1_sel     = 1'b0;
    rsel_nxt_c = RSEL_DEF;

    if (state == M1_GNT) begin
      active_c = m1_req;
      s_addr   = m1_addr;
      s_wr     = m1_req & m1_wr;
      s_din    = m1_dout;
    end else begin
      active_c = m0_req;
      s_wr     = m0_req & m0_wr;
    end

    tag_c  = s_addr[ADDR_W-1:ADDR_W-TAG_W];
    s0_sel = active_c && (tag_c == TAG_S0);
    s1_sel = active_c && (tag_c == TAG_S1);

    // Only reads return data from a slave; writes and unmapped go to default.
    if (s0_sel && !s_wr)      rsel_nxt_c = RSEL_S0;
    else if (s1_sel && !s_wr) rsel_nxt_c = RSEL_S1;
  end

endmodule

// File: tb/tb_bus_arbiter_decoder.sv
// Self-checking bench for bus_arbiter_decoder: directed scenarios plus a
// randomized run against a behavioural owner/rsel model.
module tb_bus_arbiter_decoder;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = AW + DW + 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_req, m0_wr, m1_req, m1_wr;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_dout, m1_dout;
  logic          m0_grant, m1_grant, s_wr, s0_sel, s1_sel;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_din;
  logic [1:0]    rsel;

  // Downstream 3:1 read-data mux with fixed slave data.
  logic [DW-1:0] d0, d1, d2, y;
  assign d0 = 32'h1111_1111;
  assign d1 = 32'h2222_2222;
  assign d2 = 32'h3333_3333;
  assign y  = (rsel == 2'b00) ? d0 : (rsel == 2'b01) ? d1 : d2;

  int checks = 0;
  int errors = 0;

  // Model: which master owns the bus (0/1) and the expected rsel.
  int       mo   = 0;
  int       mrsel = 2;

  bus_arbiter_decoder #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_dout(m0_dout),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_dout(m1_dout),
    .m0_grant(m0_grant), .m1_grant(m1_grant),
    .s_addr(s_addr), .s_wr(s_wr), .s_din(s_din),
    .s0_sel(s0_sel), .s1_sel(s1_sel), .rsel(rsel)
  );

  always #5 clk = ~clk;

  function automatic bit own_req();
    return (mo == 1) ? m1_req : m0_req;
  endfunction

  function automatic bit own_wr();
    return (mo == 1) ? m1_wr : m0_wr;
  endfunction

  function automatic logic [AW-1:0] own_addr();
    return (mo == 1) ? m1_addr : m0_addr;
  endfunction

  // Address region = which quarter of the address space (top two bits).
  function automatic int region();
    return int'(own_addr()) / (1 << (AW - 2));
  endfunction

  function automatic logic [BW-1:0] exp_bus();
    bit g0, g1, wr, sel0, sel1;
    logic [DW-1:0] din;
    g0   = (mo == 0);
    g1   = (mo == 1);
    wr   = own_req() && own_wr();
    din  = (mo == 1) ? m1_dout : m0_dout;
    sel0 = own_req() && region() == 0;
    sel1 = own_req() && region() == 1;
    return {g0, g1, own_addr(), wr, din, sel0, sel1};
  endfunction

  // Advance one clock, updating the model from inputs present at the edge.
  task automatic tick();
    int nxt_o, nxt_r;
    if (reset) begin
      nxt_o = 0;
      nxt_r = 2;
    end else begin
      if (mo == 0) nxt_o = (!m0_req && m1_req) ? 1 : 0;
      else         nxt_o = m1_req ? 1 : 0;
      nxt_r = 2;
      if (own_req() && !own_wr() && region() == 0) nxt_r = 0;
      if (own_req() && !own_wr() && region() == 1) nxt_r = 1;
    end
    @(posedge clk);
    #1;
    mo    = nxt_o;
    mrsel = nxt_r;
  endtask

  task automatic test_reset();
    reset = 1'b1; m0_req = 1'b0; m0_wr = 1'b0; m0_addr = '0; m0_dout = '0;
    m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 8'h40; m1_dout = '0;
    tick();
    checks++;
    if ({m0_grant, m1_grant, rsel} !== 4'b10_10) begin
      errors++;
      $display("FAIL reset_state: got g0g1rsel=%b expected 1010", {m0_grant, m1_grant, rsel});
    end
    checks++;
    if (s1_sel !== 1'b0 || s_addr !== 8'h00) begin
      errors++;
      $display("FAIL reset_comb: got s1_sel=%b s_addr=%h expected 0 00", s1_sel, s_addr);
    end
    reset = 1'b0;
    tick();
    checks++;
    if ({m0_grant, m1_grant} !== 2'b01 || s1_sel !== 1'b1 || s_addr !== 8'h40) begin
      errors++;
      $display("FAIL reset_release_m1: got g=%b s1_sel=%b s_addr=%h expected 01 1 40",
               {m0_grant, m1_grant}, s1_sel, s_addr);
    end
  endtask

  task automatic test_m0_read();
    m1_req = 1'b0; m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 8'h05;
    tick();
    checks++;
    if ({m0_grant, s0_sel, s1_sel, s_wr} !== 4'b1100 || s_addr !== 8'h05) begin
      errors++;
      $display("FAIL m0_read_decode: got g0/s0/s1/wr=%b s_addr=%h expected 1100 05",
               {m0_grant, s0_sel, s1_sel, s_wr}, s_addr);
    end
    tick();
    checks++;
    if (rsel !== 2'b00 || y !== 32'h1111_1111) begin
      errors++;
      $display("FAIL m0_read_rsel: got rsel=%b y=%h expected 00 11111111", rsel, y);
    end
  endtask

  task automatic test_m1_write_read();
    m0_req = 1'b0; m1_req = 1'b1; m1_wr = 1'b1; m1_addr = 8'h48; m1_dout = 32'h2222_2222;
    tick();
    checks++;
    if ({m1_grant, s1_sel, s0_sel, s_wr} !== 4'b1101 || s_din !== 32'h2222_2222) begin
      errors++;
      $display("FAIL m1_write_bus: got g1/s1/s0/wr=%b s_din=%h expected 1101 22222222",
               {m1_grant, s1_sel, s0_sel, s_wr}, s_din);
    end
    tick();
    checks++;
    if (rsel !== 2'b10) begin
      errors++;
      $display("FAIL m1_write_rsel: got %b expected 10", rsel);
    end
    m1_wr = 1'b0;
    tick();
    checks++;
    if (rsel !== 2'b01 || y !== 32'h2222_2222) begin
      errors++;
      $display("FAIL m1_read_rsel: got rsel=%b y=%h expected 01 22222222", rsel, y);
    end
  endtask

  task automatic test_contention();
    m1_req = 1'b0; m0_req = 1'b1; m0_addr = 8'h10;
    tick();
    m1_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({m0_grant, m1_grant} !== 2'b10) begin
        errors++;
        $display("FAIL contention_hold[%0d]: got %b expected 10", i, {m0_grant, m1_grant});
      end
    end
    m0_req = 1'b0;
    tick();
    checks++;
    if ({m0_grant, m1_grant} !== 2'b01) begin
      errors++;
      $display("FAIL contention_handover: got %b expected 01", {m0_grant, m1_grant});
    end
    m1_req = 1'b0;
    tick();
    checks++;
    if ({m0_grant, m1_grant} !== 2'b10) begin
      errors++;
      $display("FAIL contention_return: got %b expected 10", {m0_grant, m1_grant});
    end
  endtask

  task automatic test_unmapped();
    m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 8'hC0;
    #1;
    checks++;
    if ({m0_grant, s0_sel, s1_sel} !== 3'b100) begin
      errors++;
      $display("FAIL unmapped_decode: got g0/s0/s1=%b expected 100", {m0_grant, s0_sel, s1_sel});
    end
    tick();
    checks++;
    if (rsel !== 2'b10 || y !== 32'h3333_3333) begin
      errors++;
      $display("FAIL unmapped_rsel: got rsel=%b y=%h expected 10 33333333", rsel, y);
    end
  endtask

  task automatic test_reset_mid();
    m0_req = 1'b0; m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 8'h41;
    tick();
    checks++;
    if ({m1_grant, s1_sel} !== 2'b11) begin
      errors++;
      $display("FAIL mid_setup: got g1/s1=%b expected 11", {m1_grant, s1_sel});
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({m0_grant, m1_grant, s1_sel, rsel} !== 5'b100_10) begin
      errors++;
      $display("FAIL mid_reset: got g0/g1/s1/rsel=%b expected 10010",
               {m0_grant, m1_grant, s1_sel, rsel});
    end
    tick();
    checks++;
    if ({m0_grant, s1_sel, rsel} !== 4'b10_10) begin
      errors++;
      $display("FAIL mid_reset_hold: got g0/s1/rsel=%b expected 1010", {m0_grant, s1_sel, rsel});
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [BW-1:0] eb;
    for (int i = 0; i < 400; i++) begin
      reset   = ($urandom_range(0, 31) == 0);
      m0_req  = 1'($urandom_range(0, 3) != 0);
      m1_req  = 1'($urandom_range(0, 3) != 0);
      m0_wr   = 1'($urandom_range(0, 1));
      m1_wr   = 1'($urandom_range(0, 1));
      m0_addr = AW'($urandom);
      m1_addr = AW'($urandom);
      m0_dout = DW'($urandom);
      m1_dout = DW'($urandom);
      #1;
      eb = exp_bus();
      checks++;
      if ({m0_grant, m1_grant, s_addr, s_wr, s_din, s0_sel, s1_sel} !== eb) begin
        errors++;
        $display("FAIL rand_bus[%0d]: got %h expected %h", i,
                 {m0_grant, m1_grant, s_addr, s_wr, s_din, s0_sel, s1_sel}, eb);
      end
      tick();
      checks++;
      if (rsel !== 2'(mrsel) || m1_grant !== (mo == 1)) begin
        errors++;
        $display("FAIL rand_state[%0d]: got rsel=%b g1=%b expected %0d %0d",
                 i, rsel, m1_grant, mrsel, mo);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_m0_read();
    test_m1_write_read();
    test_contention();
    test_unmapped();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
